// File: rtl/rv_lsu.sv
// Load/store stage: runs one req/ack data-bus transaction per memory op, aligns and
// extends load data, and reports misaligned/illegal ops and bus timeouts as a fault pulse.
module rv_lsu #(
    parameter int DBUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    output logic [3:0]  o_dbus_sel,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_fault,
    output logic [1:0]  o_dbg_state
);

    // Handshake: an op is taken when i_valid is high and o_busy is low; o_dbus_req
    // stays high with stable addr/we/wdata/sel until the cycle i_dbus_ack is seen.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int CW = (DBUS_TIMEOUT < 2) ? 1 : $clog2(DBUS_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(DBUS_TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          op_store;
    logic [2:0]    op_f3;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [4:0]    op_rd;
    logic [31:0]   rdata_q;

    logic          accept;
    logic          op_legal;
    logic          timeout_hit;
    logic [3:0]    sel_raw;
    logic [31:0]   wdata_raw;
    logic [31:0]   ld_shift;
    logic [31:0]   ld_data;

    assign accept      = i_valid & (i_load | i_store) & (state == S_IDLE);
    assign timeout_hit = (DBUS_TIMEOUT != 0) && (tmo_cnt == TMO_LIMIT);

    // Byte/half/word are legal for both directions; unsigned codes only for loads.
    always_comb begin
        op_legal = 1'b0;
        case (i_funct3)
            3'b000:  op_legal = 1'b1;
            3'b001:  op_legal = ~i_addr[0];
            3'b010:  op_legal = (i_addr[1:0] == 2'b00);
            3'b100:  op_legal = ~i_store;
            3'b101:  op_legal = ~i_store & ~i_addr[0];
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = op_legal ? S_REQ : S_FAULT;
                end
            end
            S_REQ: begin
                if (i_dbus_ack) begin
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            tmo_cnt  <= '0;
            op_store <= 1'b0;
            op_f3    <= 3'b000;
            op_addr  <= 32'h0;
            op_wdata <= 32'h0;
            op_rd    <= 5'd0;
            rdata_q  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_store <= i_store;
                op_f3    <= i_funct3;
                op_addr  <= i_addr;
                op_wdata <= i_wdata;
                op_rd    <= i_rd;
                tmo_cnt  <= '0;
            end else if (state == S_REQ && !i_dbus_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == S_REQ && i_dbus_ack) begin
                rdata_q <= i_dbus_rdata;
            end
        end
    end

    always_comb begin
        sel_raw   = 4'b1111;
        wdata_raw = op_wdata;
        case (op_f3[1:0])
            2'b00: begin
                sel_raw   = 4'b0001 << op_addr[1:0];
                wdata_raw = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                sel_raw   = 4'b0011 << op_addr[1:0];
                wdata_raw = {2{op_wdata[15:0]}};
            end
            default: begin
                sel_raw   = 4'b1111;
                wdata_raw = op_wdata;
            end
        endcase
    end

    assign ld_shift = rdata_q >> {op_addr[1:0], 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (op_f3)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Bus and writeback fields are zeroed outside their strobes so idle outputs read 0.
    assign o_busy       = (state != S_IDLE);
    assign o_dbus_req   = (state == S_REQ);
    assign o_dbus_we    = o_dbus_req & op_store;
    assign o_dbus_addr  = o_dbus_req ? {op_addr[31:2], 2'b00} : 32'h0;
    assign o_dbus_sel   = o_dbus_req ? sel_raw : 4'b0000;
    assign o_dbus_wdata = o_dbus_req ? wdata_raw : 32'h0;
    assign o_wb_valid   = (state == S_RESP) & ~op_store;
    assign o_wb_rd      = o_wb_valid ? op_rd : 5'd0;
    assign o_wb_data    = o_wb_valid ? ld_data : 32'h0;
    assign o_fault      = (state == S_FAULT);
    assign o_dbg_state  = state;

endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: directed cases plus random ops against a lane-level reference model,
// with a negedge monitor popping expected bus/writeback/fault events from queues.
module tb_rv_lsu;
    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0, i_load = 1'b0, i_store = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = 32'h0, i_wdata = 32'h0;
    logic [4:0]  i_rd = 5'd0;
    logic        o_busy, o_dbus_req, o_dbus_we;
    logic [31:0] o_dbus_addr, o_dbus_wdata;
    logic [3:0]  o_dbus_sel;
    logic        i_dbus_ack = 1'b0;
    logic [31:0] i_dbus_rdata = 32'h0;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_fault;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int failures = 0;

    logic [68:0] exp_bus_q[$];
    logic [36:0] exp_wb_q[$];
    logic        exp_fault_q[$];

    rv_lsu #(.DBUS_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_load(i_load),
        .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rd(i_rd), .o_busy(o_busy), .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we),
        .o_dbus_addr(o_dbus_addr), .o_dbus_wdata(o_dbus_wdata), .o_dbus_sel(o_dbus_sel),
        .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata), .o_wb_valid(o_wb_valid),
        .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_fault(o_fault),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic st, input logic [2:0] f3, input logic [1:0] a);
        int n;
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (st && f3[2]) return 1'b0;
        n = m_size(f3);
        return (int'(a) % n) == 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s = 4'b0000;
        int n = m_size(f3);
        for (int i = 0; i < 4; i++)
            if (i >= int'(a) && i < int'(a) + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r = 32'h0;
        int n = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ldata(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] r);
        logic [7:0]  b[4];
        logic [31:0] v = 32'h0;
        int n = m_size(f3);
        for (int i = 0; i < 4; i++) b[i] = r[8*i +: 8];
        for (int k = 0; k < n; k++) v[8*k +: 8] = b[int'(a) + k];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int j = 8 * n; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        prev_req = 1'b0;
    logic [68:0] held_bus;

    always @(negedge i_clk) begin
        logic [68:0] e;
        logic [36:0] w;
        logic [68:0] cur;
        if (i_reset) begin
            prev_req = 1'b0;
        end else begin
            cur = {o_dbus_we, o_dbus_addr, o_dbus_sel, o_dbus_wdata};
            if (o_dbus_req && !prev_req) begin
                if (exp_bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected actual addr=0x%08h required=no request", o_dbus_addr);
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_we", 32'(o_dbus_we), 32'(e[68]));
                    chk("bus_addr", o_dbus_addr, e[67:36]);
                    chk("bus_sel", 32'(o_dbus_sel), 32'(e[35:32]));
                    if (e[68]) chk("bus_wdata", o_dbus_wdata, e[31:0]);
                end
                held_bus = cur;
            end else if (o_dbus_req) begin
                chk("bus_stable", 32'(cur != held_bus), 32'd0);
            end
            if (o_wb_valid) begin
                if (exp_wb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wb_unexpected actual rd=%0d data=0x%08h required=no writeback", o_wb_rd, o_wb_data);
                end else begin
                    w = exp_wb_q.pop_front();
                    chk("wb_rd", 32'(o_wb_rd), 32'(w[36:32]));
                    chk("wb_data", o_wb_data, w[31:0]);
                end
            end
            if (o_fault) begin
                if (exp_fault_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fault_unexpected actual=1 required=0");
                end else begin
                    chk("fault", 32'(o_fault), 32'(exp_fault_q.pop_front()));
                end
            end
            prev_req = o_dbus_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 50) begin
            tick();
            n++;
        end
        if (o_busy) begin
            checks++; failures++;
            $display("FAIL idle_wait actual=busy required=idle within 50 cycles");
        end
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        i_valid  = 1'b1;
        i_load   = ld;
        i_store  = st;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wdata;
        i_rd     = rd;
        tick();
        i_valid = 1'b0;
        i_load  = 1'b0;
        i_store = 1'b0;
        i_addr  = $urandom;
        i_wdata = $urandom;
    endtask

    // dly = REQ cycles before ack; dly > TMO means the slave never answers.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int dly, input bit use_exp = 1'b0,
                         input logic [31:0] exp_val = 32'h0, input logic [3:0] exp_sel = 4'h0);
        bit          legal;
        logic [3:0]  sel;
        logic [31:0] wd;
        wait_idle();
        legal = m_legal(st, f3, addr[1:0]);
        if (ld | st) begin
            if (!legal) begin
                exp_fault_q.push_back(1'b1);
            end else begin
                sel = (use_exp && st) ? exp_sel : m_sel(f3, addr[1:0]);
                wd  = (use_exp && st) ? exp_val : m_wdata(f3, wdata);
                exp_bus_q.push_back({st, addr[31:2], 2'b00, sel, wd});
                if (dly > TMO) exp_fault_q.push_back(1'b1);
                else if (!st) exp_wb_q.push_back({rd, use_exp ? exp_val : m_ldata(f3, addr[1:0], rdata)});
            end
        end
        drive_op(ld, st, f3, addr, wdata, rd);
        if (!(ld | st)) begin
            chk("ignored_busy", 32'(o_busy), 32'd0);
        end else if (legal && dly <= TMO) begin
            repeat (dly) tick();
            i_dbus_ack   = 1'b1;
            i_dbus_rdata = rdata;
            tick();
            i_dbus_ack   = 1'b0;
            i_dbus_rdata = $urandom;
        end
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_req", 32'(o_dbus_req), 32'd0);
        chk("rst_we", 32'(o_dbus_we), 32'd0);
        chk("rst_addr", o_dbus_addr, 32'h0);
        chk("rst_sel", 32'(o_dbus_sel), 32'd0);
        chk("rst_wdata", o_dbus_wdata, 32'h0);
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(o_wb_rd), 32'd0);
        chk("rst_wb_data", o_wb_data, 32'h0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b0;
        tick();

        // LW with ack in the first REQ cycle: writeback two cycles after accept.
        exp_bus_q.push_back({1'b0, 32'h100, 4'hF, 32'h0});
        exp_wb_q.push_back({5'd5, 32'hDEADBEEF});
        drive_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        chk("lw_busy_c1", 32'(o_busy), 32'd1);
        chk("lw_req_c1", 32'(o_dbus_req), 32'd1);
        i_dbus_ack = 1'b1;
        i_dbus_rdata = 32'hDEADBEEF;
        tick();
        i_dbus_ack = 1'b0;
        chk("lw_wb_c2", 32'(o_wb_valid), 32'd1);
        chk("lw_busy_c2", 32'(o_busy), 32'd1);
        tick();
        chk("lw_busy_c3", 32'(o_busy), 32'd0);
        chk("lw_wb_c3", 32'(o_wb_valid), 32'd0);

        // Sub-word loads with sign/zero extension.
        issue(1, 0, 3'b000, 32'h103, 0, 5'd1, 32'h80FF0000, 0, 1, 32'hFFFFFF80);
        issue(1, 0, 3'b100, 32'h103, 0, 5'd2, 32'h80FF0000, 1, 1, 32'h00000080);
        issue(1, 0, 3'b001, 32'h102, 0, 5'd0, 32'h80FF0000, 2, 1, 32'hFFFF80FF);

        // Stores: lane replication and byte enables.
        issue(0, 1, 3'b000, 32'h101, 32'h12345678, 5'd3, 0, 0, 1, 32'h78787878, 4'b0010);
        issue(0, 1, 3'b001, 32'h102, 32'h12345678, 5'd3, 0, 3, 1, 32'h56785678, 4'b1100);

        // Misaligned LW: one-cycle fault, no request.
        wait_idle();
        exp_fault_q.push_back(1'b1);
        drive_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd4);
        chk("mis_busy_c1", 32'(o_busy), 32'd1);
        chk("mis_fault_c1", 32'(o_fault), 32'd1);
        chk("mis_req_c1", 32'(o_dbus_req), 32'd0);
        tick();
        chk("mis_busy_c2", 32'(o_busy), 32'd0);
        chk("mis_fault_c2", 32'(o_fault), 32'd0);
        issue(1, 0, 3'b011, 32'h100, 0, 5'd4, 0, 0);

        // Timeout: no ack means five REQ cycles, then fault.
        wait_idle();
        exp_bus_q.push_back({1'b0, 32'h200, 4'hF, 32'h0});
        exp_fault_q.push_back(1'b1);
        drive_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd6);
        n = 0;
        while (o_dbus_req && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", n, 32'd5);
        chk("tmo_fault", 32'(o_fault), 32'd1);
        tick();
        chk("tmo_busy_after", 32'(o_busy), 32'd0);
        // Ack in the limit cycle still completes.
        issue(1, 0, 3'b010, 32'h204, 0, 5'd7, 32'hCAFEF00D, TMO);

        // A stray ack while idle is ignored.
        i_dbus_ack = 1'b1;
        tick();
        i_dbus_ack = 1'b0;
        chk("stray_ack_busy", 32'(o_busy), 32'd0);
        tick();

        // Reset in the middle of REQ.
        exp_bus_q.push_back({1'b0, 32'h300, 4'hF, 32'h0});
        drive_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd8);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rreq_req", 32'(o_dbus_req), 32'd0);
        chk("rreq_busy", 32'(o_busy), 32'd0);
        chk("rreq_wb", 32'(o_wb_valid), 32'd0);
        chk("rreq_fault", 32'(o_fault), 32'd0);
        tick();
        chk("rreq_wb_late", 32'(o_wb_valid), 32'd0);
        issue(1, 0, 3'b010, 32'h304, 0, 5'd9, 32'h0BADF00D, 1);

        // Random mix, including illegal codes, misalignment, neither-op and timeouts.
        for (int i = 0; i < 80; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            issue(kind[0], kind[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), $urandom, $urandom_range(0, TMO + 2));
        end

        repeat (3) tick();
        chk("bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
        chk("wb_q_empty", 32'(exp_wb_q.size()), 32'd0);
        chk("fault_q_empty", 32'(exp_fault_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "simulation time limit");
    end
endmodule
